// File: rtl/clock_divider.sv
// -----------------------------------------------------------------------------
// clock_divider
//
// Divides clk_in by the integer DIV and produces a 50% duty-cycle clk_out.
// Even ratios use a single rising-edge phase flop. Odd ratios add a
// falling-edge copy of that flop, which stretches the high phase by half an
// input period.
//
// Parameters
//   DIV      division ratio, legal range 2..2^24 (f_clk_out = f_clk_in / DIV)
//
// Ports
//   clk_in   input   1  sole clock; all state advances on its edges
//   rst_n    input   1  asynchronous active-low reset; forces clk_out low
//   clk_out  output  1  divided clock, 50% duty
// -----------------------------------------------------------------------------
module clock_divider #(
   parameter int DIV = 1000
) (
   input  logic clk_in,
   input  logic rst_n,
   output logic clk_out
);

   // Width is guarded so that an illegal DIV still elaborates far enough
   // to reach the range check below.
   localparam int unsigned CW = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF = CW'((DIV + 1) / 2);

   if (DIV < 2 || DIV > 2**24) begin : g_div_check
      $error("clock_divider: DIV=%0d is outside the legal range 2..2^24", DIV);
   end

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          p;

   always_comb begin
      cnt_next = cnt + 1'b1;
      if (cnt == LAST) begin
         cnt_next = '0;
      end
   end

   // The phase flop is loaded from the next count value. As a result, p is
   // high exactly while cnt sits in HALF..DIV-1, and the output edges line up
   // with the counter edges instead of trailing them by one cycle.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         p   <= 1'b0;
      end else begin
         cnt <= cnt_next;
         p   <= (cnt_next >= HALF);
      end
   end

   if (DIV % 2 == 1) begin : g_odd
      logic n;

      // n trails p by half an input period. OR-ing the two registered terms
      // keeps the output high until the falling edge that follows p's fall,
      // which gives an exact DIV/2 high time.
      always_ff @(negedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            n <= 1'b0;
         end else begin
            n <= p;
         end
      end

      assign clk_out = p | n;
   end else begin : g_even
      assign clk_out = p;
   end

endmodule

// File: tb/tb_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_clock_divider
//
// Runs several clock_divider instances (DIV = 2, 3, 4, 5, 7, 1000) from one
// clk_in/rst_n pair. After every clk_in edge, each output is compared with a
// waveform model written in half-period slots. Edge timestamps of the DIV=1000
// output are also checked, and random reset pulses and holds are applied.
// -----------------------------------------------------------------------------
module tb_clock_divider;

   localparam int NDUT = 6;
   localparam int DIVS [NDUT] = '{2, 3, 4, 5, 7, 1000};

   logic            clk;
   logic            rst_n;
   logic [NDUT-1:0] outs;

   int checks   = 0;
   int failures = 0;

   // Number of clk_in rising edges since the last reset release.
   int unsigned rises;

   // Timestamps for the DIV=1000 output during the long initial run.
   bit  mon_en = 1'b0;
   int  mon_rise_n = 0;
   int  mon_fall_n = 0;
   time mon_rise1 = 0;
   time mon_rise2 = 0;
   time mon_fall1 = 0;

   clock_divider #(.DIV(2))    u_d2    (.clk_in(clk), .rst_n(rst_n), .clk_out(outs[0]));
   clock_divider #(.DIV(3))    u_d3    (.clk_in(clk), .rst_n(rst_n), .clk_out(outs[1]));
   clock_divider #(.DIV(4))    u_d4    (.clk_in(clk), .rst_n(rst_n), .clk_out(outs[2]));
   clock_divider #(.DIV(5))    u_d5    (.clk_in(clk), .rst_n(rst_n), .clk_out(outs[3]));
   clock_divider #(.DIV(7))    u_d7    (.clk_in(clk), .rst_n(rst_n), .clk_out(outs[4]));
   clock_divider #(.DIV(1000)) u_d1000 (.clk_in(clk), .rst_n(rst_n), .clk_out(outs[5]));

   // 100 MHz input clock, with rising edges at 5, 15, 25 ns, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge outs[5]) begin
      if (mon_en) begin
         mon_rise_n = mon_rise_n + 1;
         if (mon_rise_n == 1) mon_rise1 = $time;
         if (mon_rise_n == 2) mon_rise2 = $time;
      end
   end

   always @(negedge outs[5]) begin
      if (mon_en) begin
         mon_fall_n = mon_fall_n + 1;
         if (mon_fall_n == 1) mon_fall1 = $time;
      end
   end

   // Model of the output waveform. Time is counted in half-period slots:
   // slot 2(k-1) follows rising edge k, and slot 2(k-1)+1 follows the falling
   // edge after it. The output first rises at rising edge ceil(DIV/2). From
   // there it is high for DIV slots and low for DIV slots, and repeats.
   function automatic logic model(input int unsigned div, input int unsigned nrise,
                                  input bit after_fall);
      int unsigned h0;
      int unsigned h;
      if (nrise == 0) return 1'b0;
      h0 = 2 * ((div + 1) / 2 - 1);
      h  = 2 * (nrise - 1) + (after_fall ? 1 : 0);
      if (h < h0) return 1'b0;
      return ((h - h0) % (2 * div)) < div;
   endfunction

   task automatic check_all(input string tag, input bit force_low);
      logic exp;
      for (int i = 0; i < NDUT; i++) begin
         exp = force_low ? 1'b0 : model(DIVS[i], rises, (clk == 1'b0));
         checks++;
         assert (outs[i] === exp) else begin
            failures++;
            $error("FAIL %s div=%0d t=%0t rises=%0d observed=%b expected=%b",
                   tag, DIVS[i], $time, rises, outs[i], exp);
         end
      end
   endtask

   // Advance to the next clk_in edge and sample 1 ns after it.
   task automatic step();
      @(clk);
      #1;
      if (rst_n) begin
         if (clk) rises++;
         check_all("wave", 1'b0);
      end else begin
         check_all("in_reset", 1'b1);
      end
   endtask

   task automatic check_time(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs == exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int unsigned n_edges;
      int unsigned width;

      rst_n = 1'b0;
      rises = 0;

      // Reset state, checked before and across the first clk_in edges.
      #3;
      check_all("reset_state", 1'b1);
      step();          // rising edge at 5 ns
      step();          // falling edge at 10 ns
      step();          // rising edge at 15 ns, sampled at 16 ns
      #4;
      mon_en = 1'b1;
      rst_n  = 1'b1;   // released at 20 ns

      // Long run of just over 200 us. The DIV=1000 output should rise at
      // 5015 ns, fall at 10015 ns, and keep a 10 us period from there.
      while ($time < 200000) step();
      mon_en = 1'b0;
      check_time("d1000_first_rise", mon_rise1, 5015);
      check_time("d1000_first_fall", mon_fall1, 10015);
      check_time("d1000_period", mon_rise2 - mon_rise1, 10000);
      check_time("d1000_rise_count", mon_rise_n, 20);
      check_time("d1000_fall_count", mon_fall_n, 19);

      // Random mid-run reset pulses (2-3 ns, shorter than one clk_in period)
      // and longer holds. Each one must drop every output at once and
      // restart the sequence from the beginning.
      for (int r = 0; r < 12; r++) begin
         n_edges = $urandom_range(60, 3);
         for (int unsigned e = 0; e < n_edges; e++) step();
         rst_n = 1'b0;
         #1;
         check_all("reset_async", 1'b1);
         rises = 0;
         if (($urandom & 1) == 0) begin
            width = $urandom_range(2, 1);
            #(width);
            rst_n = 1'b1;
         end else begin
            n_edges = $urandom_range(4, 1);
            for (int unsigned e = 0; e < n_edges; e++) step();
            #1;
            rst_n = 1'b1;
         end
      end
      for (int e = 0; e < 2100; e++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter: DIV, default 1000, integer division ratio (f_clk_out = f_clk_in / DIV).
REQ-002 Port: clk_in  input  1  sole clock; all state advances on its edges.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: clk_out  output  1  divided clock, 50% duty.
REQ-005 The design SHALL use one clock (clk_in) and one asynchronous active-low reset (rst_n); no other ports.

Function
REQ-006 DIV < 2 SHALL cause an elaboration-time error; the legal range is 2..2^24.
REQ-007 Internal counter cnt, width $clog2(DIV), SHALL increment on every clk_in rising edge and wrap from DIV-1 to 0.
REQ-008 Define H = ceil(DIV/2); phase flop p (rising-edge) SHALL be loaded with (next cnt >= H), so p is high while cnt is in H..DIV-1.
REQ-009 Even DIV: clk_out SHALL equal p; high exactly DIV/2 clk_in periods, low DIV/2.
REQ-010 Odd DIV: flop n SHALL capture p on each clk_in falling edge; clk_out SHALL equal p OR n; high exactly DIV/2 periods (integer part plus one half-period), low the same.
REQ-011 clk_out period SHALL be exactly DIV clk_in periods in steady state, with no drift.
REQ-012 First clk_out rising edge SHALL coincide with the H-th clk_in rising edge after rst_n deasserts (edges counted from 1).
REQ-013 clk_out falls on the clk_in rising edge where cnt wraps to 0 (even DIV), or on the following clk_in falling edge (odd DIV).
REQ-014 clk_out SHALL be glitch-free: only registered terms, no combinational decode of cnt drives the output.
REQ-015 DIV = 2 SHALL give clk_out toggling on every clk_in rising edge; DIV = 3 SHALL give 1.5 periods high and 1.5 periods low.

Reset
REQ-016 While rst_n = 0: cnt = 0, p = 0, n = 0, clk_out = 0.
REQ-017 Assertion of rst_n SHALL force clk_out low immediately, without waiting for a clk_in edge, including mid-period.
REQ-018 After deassertion the sequence SHALL restart from cnt = 0 per REQ-012; no state survives a reset.
REQ-019 A reset pulse shorter than one clk_in period SHALL still fully reinitialise all state.

Verification
REQ-020 DIV=1000, clk_in 100 MHz (rising edges at 5, 15, 25 ns, ...), rst_n released at 20 ns -> clk_out 0 until its first rise at 5015 ns; falls at 10015 ns; period 10 us, high time 5 us, over 200 us of simulation.
REQ-021 DIV=4 -> clk_out sequence per rising edge after reset: 0,1,1,0,0,1,1,0,...; first rise on edge 2.
REQ-022 DIV=3 -> clk_out rises on rising edge 2, falls on the falling edge following rising edge 3; high 15 ns, low 15 ns at a 10 ns clk_in period.
REQ-023 DIV=2 -> clk_out rises on rising edge 1 and then toggles on every rising edge (50 MHz from 100 MHz).
REQ-024 Mid-run reset: rst_n low for 3 ns while clk_out = 1 -> clk_out drops to 0 within the same time step; after release, first rise is again at the H-th rising edge.
REQ-025 Checker: over at least 10 periods, measure every clk_out high time and low time -> each equals DIV x 5 ns at a 10 ns clk_in period; zero glitches.
